// File: rtl/med_list_writer.sv
// Writer side of the medicine-list memory: button edges become 4-bit IDs written at consecutive addresses.
// Optional feature macro MEDLIST_CLEAR_EN adds a CLEAR sweep that fills the list with stop words on entry.
module med_list_writer #(
   parameter int DEPTH = 10
) (
   input  logic       Clk,
   input  logic       Rst,
   input  logic       Enable,
   input  logic       IncButton,
   input  logic       NextButton,
   input  logic       DoneButton,
   output logic [5:0] Address,
   output logic [3:0] Data_Out,
   output logic       WriteEnable,
   output logic [3:0] EntryValue,
   output logic [5:0] Count,
   output logic       Full,
   output logic       Done
);

   localparam logic [2:0] S_IDLE  = 3'd0;
`ifdef MEDLIST_CLEAR_EN
   localparam logic [2:0] S_CLEAR = 3'd1;
`endif
   localparam logic [2:0] S_EDIT  = 3'd2;
   localparam logic [2:0] S_WRITE = 3'd3;
   localparam logic [2:0] S_TERM  = 3'd4;
   localparam logic [2:0] S_DONE  = 3'd5;

   localparam logic [3:0] STOP_WORD = 4'b1111;
   localparam logic [5:0] DEPTH_W   = 6'(DEPTH);

   // 4'b1111 is reserved as the stop word, so the displayed ID wraps from 14 to 0.
   function automatic logic [3:0] next_id(input logic [3:0] id);
      next_id = (id == 4'd14) ? 4'd0 : id + 4'd1;
   endfunction

   logic [2:0] state_q, state_d;
   logic       inc_prev_q, nxt_prev_q, dne_prev_q;
   logic [5:0] addr_q, addr_d;
   logic [3:0] data_q, data_d;
   logic       we_q, we_d;
   logic [3:0] ev_q, ev_d;
   logic [5:0] cnt_q, cnt_d;
   logic       full_q, full_d;
   logic       done_q, done_d;

   logic inc_edge, nxt_edge, dne_edge;

   assign inc_edge = IncButton  & ~inc_prev_q;
   assign nxt_edge = NextButton & ~nxt_prev_q;
   assign dne_edge = DoneButton & ~dne_prev_q;

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      data_d  = data_q;
      we_d    = we_q;
      ev_d    = ev_q;
      cnt_d   = cnt_q;
      full_d  = full_q;
      done_d  = done_q;

      if (!Enable || state_q == S_IDLE) begin
         addr_d  = 6'd0;
         data_d  = STOP_WORD;
         we_d    = 1'b0;
         ev_d    = 4'd0;
         cnt_d   = 6'd0;
         full_d  = 1'b0;
         done_d  = 1'b0;
         state_d = S_IDLE;
         if (Enable) begin
`ifdef MEDLIST_CLEAR_EN
            state_d = S_CLEAR;
`else
            state_d = S_EDIT;
`endif
         end
      end else begin
         case (state_q)
`ifdef MEDLIST_CLEAR_EN
            // First CLEAR cycle raises the strobe at address 0; the sweep ends after DEPTH strobed cycles.
            S_CLEAR: begin
               data_d = STOP_WORD;
               if (!we_q) begin
                  we_d   = 1'b1;
                  addr_d = 6'd0;
               end else if (addr_q == DEPTH_W - 6'd1) begin
                  we_d    = 1'b0;
                  addr_d  = 6'd0;
                  state_d = S_EDIT;
               end else begin
                  addr_d = addr_q + 6'd1;
               end
            end
`endif
            S_EDIT: begin
               if (dne_edge) begin
                  data_d  = STOP_WORD;
                  we_d    = 1'b1;
                  state_d = S_TERM;
               end else if (nxt_edge) begin
                  data_d  = ev_q;
                  we_d    = 1'b1;
                  state_d = S_WRITE;
               end else if (inc_edge) begin
                  ev_d = next_id(ev_q);
               end
            end
            // A full list gets no stop word: the reader stops at DEPTH on its own.
            S_WRITE: begin
               we_d   = 1'b0;
               addr_d = addr_q + 6'd1;
               cnt_d  = cnt_q + 6'd1;
               ev_d   = 4'd0;
               if (cnt_q + 6'd1 == DEPTH_W) begin
                  full_d  = 1'b1;
                  done_d  = 1'b1;
                  state_d = S_DONE;
               end else begin
                  state_d = S_EDIT;
               end
            end
            S_TERM: begin
               we_d    = 1'b0;
               done_d  = 1'b1;
               state_d = S_DONE;
            end
            S_DONE: begin
               state_d = S_DONE;
            end
            default: begin
               we_d    = 1'b0;
               state_d = S_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge Clk) begin
      if (Rst) begin
         state_q    <= S_IDLE;
         inc_prev_q <= 1'b0;
         nxt_prev_q <= 1'b0;
         dne_prev_q <= 1'b0;
         addr_q     <= 6'd0;
         data_q     <= STOP_WORD;
         we_q       <= 1'b0;
         ev_q       <= 4'd0;
         cnt_q      <= 6'd0;
         full_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         inc_prev_q <= IncButton;
         nxt_prev_q <= NextButton;
         dne_prev_q <= DoneButton;
         addr_q     <= addr_d;
         data_q     <= data_d;
         we_q       <= we_d;
         ev_q       <= ev_d;
         cnt_q      <= cnt_d;
         full_q     <= full_d;
         done_q     <= done_d;
      end
   end

   assign Address     = addr_q;
   assign Data_Out    = data_q;
   assign WriteEnable = we_q;
   assign EntryValue  = ev_q;
   assign Count       = cnt_q;
   assign Full        = full_q;
   assign Done        = done_q;

endmodule
